// File: rtl/utg_fmc_pkg.sv
// Address map and helpers shared by the ARM FMC register bank.
package utg_fmc_pkg;

  localparam logic [11:0] OFS_FREQ0    = 12'h003;
  localparam logic [11:0] OFS_FREQ1    = 12'h004;
  localparam logic [11:0] OFS_FREQ2    = 12'h005;
  localparam logic [11:0] OFS_FREQ3    = 12'h006;
  localparam logic [11:0] OFS_FREQ4    = 12'h007;
  localparam logic [11:0] OFS_FREQ5    = 12'h008;
  localparam logic [11:0] OFS_CH_EN    = 12'h02D;
  localparam logic [11:0] ADR_VERSION  = 12'h200;
  localparam logic [11:0] ADR_SYNC_RST = 12'h204;
  localparam int          CH_SEL_BIT   = 8;
  localparam int          FREQ_BYTES   = 6;

  // Channel registers live in the low 512 bytes; bit 8 picks the channel.
  function automatic logic is_ch_reg(input logic [11:0] a);
    return (a & 12'hE00) == 12'h000;
  endfunction

  function automatic logic [11:0] ch_ofs(input logic [11:0] a);
    return a & 12'h0FF;
  endfunction

endpackage

// File: rtl/fmc_sync.sv
// Two-flop synchroniser for an active-low bus strobe, with previous-sample tap and rise detect.
module fmc_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_prev,
  output logic rise
);

  logic s_p0, s_p1, s_p2;

  // Stages reset to 1 so an idle bus is seen after reset and no edge is invented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_p0 <= 1'b1;
      s_p1 <= 1'b1;
      s_p2 <= 1'b1;
    end else begin
      s_p0 <= d;
      s_p1 <= s_p0;
      s_p2 <= s_p1;
    end
  end

  assign q      = s_p1;
  assign q_prev = s_p2;
  assign rise   = s_p1 & ~s_p2;

endmodule

// File: rtl/arm_fmc_reg_bank.sv
// ARM FMC register bank: synchronised bus decode, DDS frequency words, channel enables,
// sync-reset pulse generator and registered readback.
module arm_fmc_reg_bank
  import utg_fmc_pkg::*;
#(
  parameter int          FREQ_W       = 48,
  parameter int          SYNC_RST_LEN = 16,
  parameter logic [7:0]  VERSION      = 8'h10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              fmc_ncs,
  input  logic              fmc_nwe,
  input  logic              fmc_noe,
  input  logic [11:0]       fmc_addr,
  input  logic [7:0]        fmc_wdata,
  output logic [7:0]        fmc_rdata,
  output logic              fmc_rd_oe,
  output logic [FREQ_W-1:0] ch1_freq,
  output logic [FREQ_W-1:0] ch2_freq,
  output logic              ch1_freq_upd,
  output logic              ch2_freq_upd,
  output logic              ch1_en,
  output logic              ch2_en,
  output logic              sync_rst
);

  localparam int SH_W  = FREQ_W - 8;
  localparam int CNT_W = $clog2(SYNC_RST_LEN + 1);

  logic ncs_s, ncs_prev, ncs_rise;
  logic nwe_s, nwe_prev, nwe_rise;
  logic noe_s, noe_prev, noe_rise;

  fmc_sync u_sync_ncs (.clk(sys_clk), .rst(sys_rst), .d(fmc_ncs),
                       .q(ncs_s), .q_prev(ncs_prev), .rise(ncs_rise));
  fmc_sync u_sync_nwe (.clk(sys_clk), .rst(sys_rst), .d(fmc_nwe),
                       .q(nwe_s), .q_prev(nwe_prev), .rise(nwe_rise));
  fmc_sync u_sync_noe (.clk(sys_clk), .rst(sys_rst), .d(fmc_noe),
                       .q(noe_s), .q_prev(noe_prev), .rise(noe_rise));

  logic unused_sync;
  assign unused_sync = ^{ncs_rise, nwe_prev, noe_prev, noe_rise};

  logic [11:0] addr_p0, addr_p1, addr_p2;
  logic [7:0]  wdata_p0, wdata_p1, wdata_p2;

  // p0/p1 track the strobe synchronisers; p2 is the sample preceding the current one.
  always_ff @(posedge sys_clk) begin
    addr_p0  <= fmc_addr;
    addr_p1  <= addr_p0;
    addr_p2  <= addr_p1;
    wdata_p0 <= fmc_wdata;
    wdata_p1 <= wdata_p0;
    wdata_p2 <= wdata_p1;
  end

  logic        wr_commit, wr_ch, rd_ch, rd_act;
  logic [11:0] wr_ofs, rd_ofs;
  logic [2:0]  wr_idx, rd_idx;

  assign wr_commit = nwe_rise & ~ncs_prev;
  assign wr_ch     = addr_p2[CH_SEL_BIT];
  assign wr_ofs    = ch_ofs(addr_p2);
  assign wr_idx    = addr_p2[2:0] - 3'd3;
  assign rd_ch     = addr_p1[CH_SEL_BIT];
  assign rd_ofs    = ch_ofs(addr_p1);
  assign rd_idx    = addr_p1[2:0] - 3'd3;
  assign rd_act    = ~ncs_s & ~noe_s & nwe_s;

  logic [1:0][SH_W-1:0]   shadow;
  logic [1:0][FREQ_W-1:0] freq;
  logic [1:0]             upd, en;
  logic [CNT_W-1:0]       srst_cnt;
  logic [7:0]             rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    if (addr_p1 == ADR_VERSION) begin
      rd_mux = VERSION;
    end else if (is_ch_reg(addr_p1)) begin
      if (rd_ofs >= OFS_FREQ0 && rd_ofs <= OFS_FREQ4)
        rd_mux = shadow[rd_ch][{rd_idx, 3'b000} +: 8];
      else if (rd_ofs == OFS_FREQ5)
        rd_mux = freq[rd_ch][FREQ_W-1 -: 8];
      else if (rd_ofs == OFS_CH_EN)
        rd_mux = {7'b0, en[rd_ch]};
    end
  end

  // Commit stage: register updates one cycle after the synchronised nWE rise.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shadow    <= '0;
      freq      <= '0;
      upd       <= '0;
      en        <= '0;
      srst_cnt  <= '0;
      sync_rst  <= 1'b0;
      fmc_rd_oe <= 1'b0;
      fmc_rdata <= 8'h00;
    end else begin
      upd <= '0;
      if (wr_commit && is_ch_reg(addr_p2)) begin
        if (wr_ofs >= OFS_FREQ0 && wr_ofs <= OFS_FREQ4) begin
          shadow[wr_ch][{wr_idx, 3'b000} +: 8] <= wdata_p2;
        end else if (wr_ofs == OFS_FREQ5) begin
          freq[wr_ch] <= {wdata_p2, shadow[wr_ch]};
          upd[wr_ch]  <= 1'b1;
        end else if (wr_ofs == OFS_CH_EN) begin
          en[wr_ch] <= wdata_p2[0];
        end
      end
      // A new trigger while the pulse is running restarts the full length.
      if (wr_commit && addr_p2 == ADR_SYNC_RST) begin
        srst_cnt <= CNT_W'(SYNC_RST_LEN - 1);
        sync_rst <= 1'b1;
      end else if (srst_cnt != '0) begin
        srst_cnt <= srst_cnt - CNT_W'(1);
      end else begin
        sync_rst <= 1'b0;
      end
      fmc_rd_oe <= rd_act;
      fmc_rdata <= rd_mux;
    end
  end

  assign ch1_freq     = freq[0];
  assign ch2_freq     = freq[1];
  assign ch1_freq_upd = upd[0];
  assign ch2_freq_upd = upd[1];
  assign ch1_en       = en[0];
  assign ch2_en       = en[1];

endmodule

// File: tb/tb_arm_fmc_reg_bank.sv
// Directed bench for arm_fmc_reg_bank: bus writes/reads, frequency commit, sync pulse, reset cases.
`timescale 1ns/1ps
module tb_arm_fmc_reg_bank;

  localparam int CLK_P = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ncs = 1'b1, nwe = 1'b1, noe = 1'b1;
  logic [11:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        rd_oe;
  logic [47:0] ch1_freq, ch2_freq;
  logic        ch1_upd, ch2_upd, ch1_en, ch2_en, sync_rst;

  int  checks = 0, failures = 0;
  int  upd1_cnt = 0, upd2_cnt = 0, srst_cnt = 0;
  time t_nwe_rise = 0;

  always #(CLK_P/2) clk = ~clk;

  arm_fmc_reg_bank dut (
    .sys_clk(clk), .sys_rst(rst),
    .fmc_ncs(ncs), .fmc_nwe(nwe), .fmc_noe(noe),
    .fmc_addr(addr), .fmc_wdata(wdata),
    .fmc_rdata(rdata), .fmc_rd_oe(rd_oe),
    .ch1_freq(ch1_freq), .ch2_freq(ch2_freq),
    .ch1_freq_upd(ch1_upd), .ch2_freq_upd(ch2_upd),
    .ch1_en(ch1_en), .ch2_en(ch2_en), .sync_rst(sync_rst)
  );

  always @(negedge clk) begin
    if (ch1_upd === 1'b1) upd1_cnt++;
    if (ch2_upd === 1'b1) upd2_cnt++;
    if (sync_rst === 1'b1) srst_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves nCS low four cycles after the nWE rise unless ncs_same raises it together with nWE.
  task automatic fmc_write(input logic [11:0] a, input logic [7:0] d, input bit ncs_same);
    cycles(1);
    addr = a; wdata = d; ncs = 1'b0;
    cycles(3);
    nwe = 1'b0;
    cycles(7);
    nwe = 1'b1;
    if (ncs_same) ncs = 1'b1;
    t_nwe_rise = $time;
    cycles(4);
  endtask

  task automatic bus_idle();
    ncs = 1'b1;
    cycles(3);
  endtask

  task automatic fmc_read(input logic [11:0] a, input logic [7:0] exp, input string tag);
    cycles(1);
    addr = a; ncs = 1'b0; noe = 1'b0;
    cycles(4);
    chk({tag, "_oe"}, 64'(rd_oe), 64'd1);
    chk(tag, 64'(rdata), 64'(exp));
    noe = 1'b1; ncs = 1'b1;
    cycles(4);
    chk({tag, "_oe_off"}, 64'(rd_oe), 64'd0);
  endtask

  initial begin
    logic [7:0] b1 [5];
    int u1, u2, s0, exp_len;
    time t1;
    b1[0] = 8'hD4; b1[1] = 8'h78; b1[2] = 8'hE9; b1[3] = 8'h26; b1[4] = 8'h31;

    // Reset
    #5 rst = 1'b1;
    #1000;
    chk("rst_ch1_freq", 64'(ch1_freq), 64'd0);
    chk("rst_ch2_freq", 64'(ch2_freq), 64'd0);
    chk("rst_ctrl", 64'({ch1_upd, ch2_upd, ch1_en, ch2_en, sync_rst, rd_oe}), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    cycles(10);
    chk("post_rst_upd", 64'(upd1_cnt + upd2_cnt), 64'd0);
    chk("post_rst_ctrl", 64'({ch1_en, ch2_en, sync_rst, rd_oe}), 64'd0);

    // Channel enables; the CH2 write raises nCS together with nWE
    fmc_write(12'h02D, 8'h0F, 1'b0);
    chk("ch1_en", 64'(ch1_en), 64'd1);
    chk("ch2_en_before", 64'(ch2_en), 64'd0);
    bus_idle();
    fmc_write(12'h12D, 8'h0F, 1'b1);
    chk("ch2_en_ncs_same_edge", 64'(ch2_en), 64'd1);
    bus_idle();

    // CH1 frequency word
    for (int i = 0; i < 5; i++) begin
      fmc_write(12'h003 + 12'(i), b1[i], 1'b0);
      bus_idle();
    end
    chk("ch1_freq_shadow_only", 64'(ch1_freq), 64'd0);
    chk("ch1_upd_none", 64'(upd1_cnt), 64'd0);
    fmc_write(12'h008, 8'h08, 1'b0);
    chk("ch1_freq_commit", 64'(ch1_freq), 64'h0000_0831_26E9_78D4);
    bus_idle();
    chk("ch1_upd_one_cycle", 64'(upd1_cnt), 64'd1);

    // CH2 frequency word
    for (int i = 0; i < 5; i++) begin
      fmc_write(12'h103 + 12'(i), b1[i], 1'b0);
      bus_idle();
    end
    chk("ch2_freq_shadow_only", 64'(ch2_freq), 64'd0);
    fmc_write(12'h108, 8'h08, 1'b0);
    chk("ch2_freq_commit", 64'(ch2_freq), 64'h0000_0831_26E9_78D4);
    bus_idle();
    chk("ch2_upd_one_cycle", 64'(upd2_cnt), 64'd1);
    chk("ch1_upd_untouched", 64'(upd1_cnt), 64'd1);

    // Lower byte after commit, then MSB alone
    fmc_write(12'h003, 8'hAA, 1'b0);
    bus_idle();
    chk("ch1_freq_hold", 64'(ch1_freq), 64'h0000_0831_26E9_78D4);
    chk("ch1_upd_hold", 64'(upd1_cnt), 64'd1);
    fmc_write(12'h008, 8'h11, 1'b0);
    bus_idle();
    chk("ch1_msb_only", 64'(ch1_freq), 64'h0000_1131_26E9_78AA);
    chk("ch1_upd_msb_only", 64'(upd1_cnt), 64'd2);

    // Ignored writes: unmapped offset and nonzero addr[11:9]
    fmc_write(12'h009, 8'h77, 1'b0);
    bus_idle();
    fmc_write(12'h22D, 8'h00, 1'b0);
    bus_idle();
    chk("ignored_en", 64'({ch1_en, ch2_en}), 64'b11);
    chk("ignored_freq", 64'(ch1_freq), 64'h0000_1131_26E9_78AA);

    // Sync reset pulse length and retrigger
    s0 = srst_cnt;
    fmc_write(12'h204, 8'h0F, 1'b0);
    bus_idle();
    cycles(25);
    chk("sync_rst_len", 64'(srst_cnt - s0), 64'd16);
    chk("sync_rst_low", 64'(sync_rst), 64'd0);
    s0 = srst_cnt;
    fmc_write(12'h204, 8'h0F, 1'b0);
    t1 = t_nwe_rise;
    chk("sync_rst_active", 64'(sync_rst), 64'd1);
    fmc_write(12'h204, 8'h01, 1'b0);
    exp_len = int'((t_nwe_rise - t1) / CLK_P) + 16;
    bus_idle();
    cycles(25);
    chk("sync_rst_retrigger", 64'(srst_cnt - s0), 64'(exp_len));

    // Readback
    fmc_read(12'h200, 8'h10, "rd_version");
    fmc_read(12'h005, 8'hE9, "rd_ch1_b2");
    fmc_read(12'h3FF, 8'h00, "rd_unmapped");
    fmc_read(12'h108, 8'h08, "rd_ch2_msb");
    fmc_read(12'h12D, 8'h01, "rd_ch2_en");

    // nWE and nOE both low: no read drive
    cycles(1);
    addr = 12'h3FF; ncs = 1'b0; noe = 1'b0; nwe = 1'b0;
    cycles(6);
    chk("rd_oe_write_priority", 64'(rd_oe), 64'd0);
    nwe = 1'b1; noe = 1'b1; ncs = 1'b1;
    cycles(5);

    // Reset in the middle of a CH2 MSB write
    u1 = upd1_cnt; u2 = upd2_cnt;
    addr = 12'h108; wdata = 8'h55; ncs = 1'b0;
    cycles(3);
    nwe = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(3);
    nwe = 1'b1; ncs = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(10);
    chk("mid_txn_ch2_freq", 64'(ch2_freq), 64'd0);
    chk("mid_txn_no_upd", 64'(upd2_cnt - u2), 64'd0);
    chk("mid_txn_ch1", 64'({ch1_freq, ch1_en}), 64'd0);
    chk("mid_txn_ch1_upd", 64'(upd1_cnt - u1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
